// File: rtl/cpu_run_pkg.sv
// Shared definitions for the CPU run controller: FSM states, halt/drain
// defaults and host port select encoding.
package cpu_run_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PREP  = 3'd1,
    ST_RUN   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } run_state_t;

  localparam logic [5:0]  HALT_OP_DEFAULT = 6'h3F;
  localparam int unsigned DRAIN_DEFAULT   = 4;

  // host_sel encoding
  localparam logic SEL_IMEM = 1'b0;
  localparam logic SEL_DMEM = 1'b1;

endpackage

// File: rtl/host_port_mux.sv
// Host access steering onto the CPU instruction/data SRAM external ports,
// with grant gating and a one-cycle registered read-return path.
module host_port_mux
  import cpu_run_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        access_ok,
  input  logic        start,
  input  logic        host_req,
  input  logic        host_we,
  input  logic        host_sel,
  input  logic [31:0] host_addr,
  input  logic [31:0] host_wdata,
  output logic        host_gnt,
  output logic        host_rvalid,
  output logic [31:0] host_rdata,
  output logic [31:0] imem_addr,
  output logic        imem_wen,
  output logic        imem_ren,
  output logic [31:0] imem_wdata,
  input  logic [31:0] imem_rdata,
  output logic [31:0] dmem_addr,
  output logic        dmem_wen,
  output logic        dmem_ren,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata
);

  logic sel_q;

  // Grant gating and strobe steering; unselected/ungranted ports are held at 0.
  always_comb begin
    host_gnt   = host_req & access_ok & ~start;
    imem_addr  = '0;
    imem_wen   = 1'b0;
    imem_ren   = 1'b0;
    imem_wdata = '0;
    dmem_addr  = '0;
    dmem_wen   = 1'b0;
    dmem_ren   = 1'b0;
    dmem_wdata = '0;
    if (host_gnt) begin
      if (host_sel == SEL_IMEM) begin
        imem_addr  = host_addr;
        imem_wdata = host_wdata;
        imem_wen   = host_we;
        imem_ren   = ~host_we;
      end else begin
        dmem_addr  = host_addr;
        dmem_wdata = host_wdata;
        dmem_wen   = host_we;
        dmem_ren   = ~host_we;
      end
    end
  end

  // Track which port a granted read targeted; SRAM data arrives next cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      host_rvalid <= 1'b0;
      sel_q       <= SEL_IMEM;
    end else begin
      host_rvalid <= host_gnt & ~host_we;
      if (host_gnt & ~host_we) begin
        sel_q <= host_sel;
      end
    end
  end

  // Return data only while valid so idle rdata stays at 0.
  always_comb begin
    host_rdata = '0;
    if (host_rvalid) begin
      host_rdata = (sel_q == SEL_DMEM) ? dmem_rdata : imem_rdata;
    end
  end

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run controller for the pipelined cpu: owns enable/reset, sequences
// reset -> run -> halt/timeout/abort -> drain -> done, and gives a host
// load/inspect access to both SRAMs while no run is active.
// DRAIN must be at least 1.
module cpu_run_ctrl
  import cpu_run_pkg::*;
#(
  parameter int unsigned CYC_W   = 32,
  parameter int unsigned DRAIN   = DRAIN_DEFAULT,
  parameter logic [5:0]  HALT_OP = HALT_OP_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [CYC_W-1:0] max_cycles,
  input  logic [31:0]      fetched_instr,
  input  logic             host_req,
  input  logic             host_we,
  input  logic             host_sel,
  input  logic [31:0]      host_addr,
  input  logic [31:0]      host_wdata,
  output logic             host_gnt,
  output logic             host_rvalid,
  output logic [31:0]      host_rdata,
  output logic [31:0]      imem_addr,
  output logic             imem_wen,
  output logic             imem_ren,
  output logic [31:0]      imem_wdata,
  input  logic [31:0]      imem_rdata,
  output logic [31:0]      dmem_addr,
  output logic             dmem_wen,
  output logic             dmem_ren,
  output logic [31:0]      dmem_wdata,
  input  logic [31:0]      dmem_rdata,
  output logic             cpu_enable,
  output logic             cpu_arst_n,
  output logic             busy,
  output logic             done,
  output logic             timeout,
  output logic [CYC_W-1:0] cycle_count
);

  localparam int unsigned DW = (DRAIN > 1) ? $clog2(DRAIN) : 1;
  localparam logic [31:0] OP_MASK  = {6'h3F, 26'h0};
  localparam logic [31:0] OP_MATCH = {HALT_OP, 26'h0};

  run_state_t       state, state_n;
  logic [CYC_W-1:0] limit;
  logic [DW-1:0]    drain_cnt;
  logic             halt, limit_hit, drain_last, idle_or_done;

  // Next-state decode and run-exit conditions.
  always_comb begin
    state_n      = state;
    halt         = (fetched_instr & OP_MASK) == OP_MATCH;
    limit_hit    = (limit != '0) && ((cycle_count + CYC_W'(1)) == limit);
    drain_last   = (drain_cnt == DW'(DRAIN - 1));
    idle_or_done = (state == ST_IDLE) || (state == ST_DONE);
    unique case (state)
      ST_IDLE, ST_DONE: if (start) state_n = ST_PREP;
      ST_PREP:          state_n = ST_RUN;
      ST_RUN:           if (halt || abort || limit_hit) state_n = ST_DRAIN;
      ST_DRAIN:         if (drain_last) state_n = ST_DONE;
      default:          state_n = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_n;
  end

  // Cycle counter, latched limit, timeout flag and drain counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_count <= '0;
      limit       <= '0;
      timeout     <= 1'b0;
      drain_cnt   <= '0;
    end else begin
      if (idle_or_done && start) begin
        cycle_count <= '0;
        timeout     <= 1'b0;
        limit       <= max_cycles;
      end
      if (((state == ST_RUN) || (state == ST_DRAIN)) && (cycle_count != '1)) begin
        cycle_count <= cycle_count + CYC_W'(1);
      end
      if ((state == ST_RUN) && (state_n == ST_DRAIN)) begin
        timeout   <= limit_hit & ~halt;
        drain_cnt <= '0;
      end else if (state == ST_DRAIN) begin
        drain_cnt <= drain_cnt + DW'(1);
      end
    end
  end

  // CPU reset is registered from next-state so it is low exactly while in PREP.
  always_ff @(posedge clk) begin
    if (rst) cpu_arst_n <= 1'b0;
    else     cpu_arst_n <= (state_n != ST_PREP);
  end

  // Status outputs decoded from the state register.
  always_comb begin
    cpu_enable = (state == ST_RUN) || (state == ST_DRAIN);
    busy       = (state == ST_PREP) || cpu_enable;
    done       = (state == ST_DONE);
  end

  host_port_mux u_host_port_mux (
    .clk         (clk),
    .rst         (rst),
    .access_ok   (idle_or_done),
    .start       (start),
    .host_req    (host_req),
    .host_we     (host_we),
    .host_sel    (host_sel),
    .host_addr   (host_addr),
    .host_wdata  (host_wdata),
    .host_gnt    (host_gnt),
    .host_rvalid (host_rvalid),
    .host_rdata  (host_rdata),
    .imem_addr   (imem_addr),
    .imem_wen    (imem_wen),
    .imem_ren    (imem_ren),
    .imem_wdata  (imem_wdata),
    .imem_rdata  (imem_rdata),
    .dmem_addr   (dmem_addr),
    .dmem_wen    (dmem_wen),
    .dmem_ren    (dmem_ren),
    .dmem_wdata  (dmem_wdata),
    .dmem_rdata  (dmem_rdata)
  );

endmodule
